// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: FSM state encoding and helpers shared by the button event decoder
package button_event_decoder_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_e;
  function automatic logic is_held(input state_e s);
    return (s == PRESS1) || (s == LONG_HELD) || (s == PRESS2);
  endfunction
endpackage

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced presses into short/long/double-click pulses.
// Defining BTN_AUTOREPEAT_EN adds repeat_press pulses every REPEAT_TICKS while held long.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int LONG_TICKS   = 12_000_000,
  parameter int DCLICK_TICKS = 6_000_000,
  parameter int REPEAT_TICKS = 3_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_state,
  input  logic btn_up,
  input  logic btn_dn,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_press,
  output logic held
);
  localparam longint CNT_LIM = longint'(1) << CNT_W;
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif
  if (LONG_TICKS < 2 || DCLICK_TICKS < 2 || REPEAT_TICKS < 2 ||
      longint'(LONG_TICKS) >= CNT_LIM || longint'(DCLICK_TICKS) >= CNT_LIM ||
      longint'(REPEAT_TICKS) >= CNT_LIM) begin : g_bad_params
    $error("button_event_decoder: tick parameter outside 2..2^CNT_W-1");
  end
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, long_q, dbl_q, rep_q, held_q;
  logic             short_d, long_d, dbl_d, rep_d;
  logic             up, dn;
  // a simultaneous press and release is meaningless, so both are dropped
  assign up = btn_up & ~btn_dn;
  assign dn = btn_dn & ~btn_up;
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      IDLE:   state_d = up ? PRESS1 : IDLE;
      PRESS1: begin
        if (dn) state_d = WAIT2;
        else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (dn) state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
        else if (cnt_q == REPEAT_LAST) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end
`endif
      end
      WAIT2: begin
        if (up) begin
          state_d = PRESS2;
          dbl_d   = 1'b1;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2:  state_d = dn ? IDLE : PRESS2;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      rep_q   <= rep_d;
      held_q  <= is_held(state_d);
    end
  end
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign repeat_press = rep_q;
  assign held         = held_q;
  // the debounced level may only be low while held on the release cycle itself
  held_tracks_level: assert property (@(posedge CLK) disable iff (RST) held |-> (btn_state || btn_dn));
endmodule
